pc_fetch_controller: RTL and testbench

//   Sequences the program-counter datapath for one instruction at a time: fetches from instruction

---
 rtl/pc_fetch_controller.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller: sequences fetch -> decode handoff -> single PC commit
// for one instruction at a time, with halt/resume, a fetch timeout and a
// retired-instruction counter.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | out of reset, waiting for run
//   FETCH   | imem_req high, waiting for imem_ack (bounded by MAX_WAIT)
//   DELIVER | captured word offered to decode until instr_ready
//   UPDATE  | single-cycle pc_en with PC_src = latched redirect select
//   HALTED  | stopped after a halt request, waiting for run without halt
//   ERROR   | fetch timeout or illegal redirect select; left only by reset
module pc_fetch_controller #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect_valid,
  input  logic [1:0]       redirect_sel,
  output logic [1:0]       PC_src,
  output logic             pc_en,
  output logic [CNT_W-1:0] instr_count,
  output logic             busy,
  output logic             fetch_err
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  // Value of the no-ack counter during the last permitted FETCH cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DELIVER = 3'd2,
    S_UPDATE  = 3'd3,
    S_HALTED  = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [1:0]         sel_q, sel_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic redirect_illegal;
  assign redirect_illegal = redirect_valid &&
                            ((redirect_sel == 2'b00) || (redirect_sel == 2'b11));

  // State and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      sel_q       <= 2'b00;
      wait_q      <= '0;
      halt_pend_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      sel_q       <= sel_d;
      wait_q      <= wait_d;
      halt_pend_q <= halt_pend_d;
      count_q     <= count_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (run) state_d = S_FETCH;
      S_FETCH: begin
        // An ack in the final permitted cycle still wins over the timeout.
        if (imem_ack)                state_d = S_DELIVER;
        else if (wait_q == WAIT_LAST) state_d = S_ERROR;
      end
      S_DELIVER: begin
        if (instr_ready) state_d = redirect_illegal ? S_ERROR : S_UPDATE;
      end
      // A halt arriving during UPDATE stops right after this commit.
      S_UPDATE:  state_d = (halt_pend_q || halt_req) ? S_HALTED : S_FETCH;
      S_HALTED:  if (run && !halt_req) state_d = S_FETCH;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath updates: instruction capture, redirect latch, timeout count, halt flag, retire count.
  always_comb begin
    instr_d     = instr_q;
    sel_d       = sel_q;
    wait_d      = wait_q;
    halt_pend_d = halt_pend_q;
    count_d     = count_q;
    case (state_q)
      S_FETCH: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      S_DELIVER: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (instr_ready) sel_d = redirect_valid ? redirect_sel : 2'b00;
      end
      S_UPDATE: begin
        count_d     = count_q + CNT_W'(1);
        halt_pend_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs decoded purely from the registered state.
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_DELIVER);
    pc_en       = (state_q == S_UPDATE);
    PC_src      = (state_q == S_UPDATE) ? sel_q : 2'b00;
    busy        = (state_q == S_FETCH) || (state_q == S_DELIVER) ||
                  (state_q == S_UPDATE);
    fetch_err   = (state_q == S_ERROR);
    instr       = instr_q;
    instr_count = count_q;
  end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Bench for pc_fetch_controller: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_pc_fetch_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, run, halt_req, imem_ack, instr_ready, redirect_valid;
  logic [31:0]   imem_rdata;
  logic [1:0]    redirect_sel;
  logic          imem_req, instr_valid, pc_en, busy, fetch_err;
  logic [31:0]   instr;
  logic [1:0]    PC_src;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_controller #(.MAX_WAIT(8), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_sel(redirect_sel),
    .PC_src(PC_src), .pc_en(pc_en), .instr_count(instr_count),
    .busy(busy), .fetch_err(fetch_err)
  );

  typedef struct {
    logic        rst, rn, hlt, ack;
    logic [31:0] rdata;
    logic        rdy, rv;
    logic [1:0]  sel;
    logic        e_req, e_valid, e_pcen;
    logic [1:0]  e_src;
    logic        e_busy, e_err;
    logic [3:0]  e_cnt;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [42:0] outs();
    return {imem_req, instr_valid, pc_en, PC_src, busy, fetch_err, instr_count, instr};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rn, input logic h, input logic a,
                       input logic [31:0] d, input logic rd, input logic rv,
                       input logic [1:0] s);
    reset = r; run = rn; halt_req = h; imem_ack = a; imem_rdata = d;
    instr_ready = rd; redirect_valid = rv; redirect_sel = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: tracks where the single in-flight instruction is.
  localparam int W_IDLE = 0, W_FETCH = 1, W_DECODE = 2, W_COMMIT = 3, W_HALT = 4, W_DEAD = 5;
  int          m_where, m_wait, m_retired;
  logic [31:0] m_instr;
  logic [1:0]  m_sel;
  bit          m_halt;

  task automatic model_step();
    if (reset) begin
      m_where = W_IDLE; m_wait = 0; m_retired = 0; m_instr = 0; m_sel = 0; m_halt = 0;
      return;
    end
    case (m_where)
      W_IDLE: if (run) m_where = W_FETCH;
      W_FETCH: begin
        if (halt_req) m_halt = 1;
        if (imem_ack) begin
          m_instr = imem_rdata; m_wait = 0; m_where = W_DECODE;
        end else begin
          m_wait++;
          if (m_wait >= 8) begin m_where = W_DEAD; m_wait = 0; end
        end
      end
      W_DECODE: begin
        if (halt_req) m_halt = 1;
        if (instr_ready) begin
          if (!redirect_valid) begin m_sel = 2'b00; m_where = W_COMMIT; end
          else if (redirect_sel == 2'b01 || redirect_sel == 2'b10) begin
            m_sel = redirect_sel; m_where = W_COMMIT;
          end else m_where = W_DEAD;
        end
      end
      W_COMMIT: begin
        m_retired++;
        m_where = (m_halt || halt_req) ? W_HALT : W_FETCH;
        m_halt = 0;
      end
      W_HALT: if (run && !halt_req) m_where = W_FETCH;
      default: ;
    endcase
  endtask

  function automatic logic [42:0] model_outs();
    logic [3:0] c;
    c = 4'(m_retired % 16);
    return {m_where == W_FETCH, m_where == W_DECODE, m_where == W_COMMIT,
            (m_where == W_COMMIT) ? m_sel : 2'b00,
            m_where == W_FETCH || m_where == W_DECODE || m_where == W_COMMIT,
            m_where == W_DEAD, c, m_instr};
  endfunction

  initial begin
    int pulses;
    int drought;
    logic [31:0] d;

    drive(1, 0, 0, 0, 0, 0, 0, 2'b00);

    //            rst rn h ack rdata          rdy rv sel  | req v  pe src   bsy err cnt instr
    vecs[0]  = '{1, 0, 0, 0, 32'h0,          0,  0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 4'd0, 32'h0};
    vecs[1]  = '{0, 1, 0, 1, 32'hAAAA0001,   1,  0, 2'b00, 1, 0, 0, 2'b00, 1, 0, 4'd0, 32'h0};
    vecs[2]  = '{0, 1, 0, 1, 32'h11111111,   1,  0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 4'd0, 32'h11111111};
    vecs[3]  = '{0, 1, 0, 1, 32'h0,          1,  0, 2'b00, 0, 0, 1, 2'b00, 1, 0, 4'd0, 32'h11111111};
    vecs[4]  = '{0, 1, 0, 1, 32'h0,          1,  0, 2'b00, 1, 0, 0, 2'b00, 1, 0, 4'd1, 32'h11111111};
    vecs[5]  = '{0, 1, 0, 1, 32'h22222222,   1,  0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 4'd1, 32'h22222222};
    vecs[6]  = '{0, 1, 0, 1, 32'h0,          1,  1, 2'b01, 0, 0, 1, 2'b01, 1, 0, 4'd1, 32'h22222222};
    vecs[7]  = '{0, 1, 0, 1, 32'h0,          1,  0, 2'b00, 1, 0, 0, 2'b00, 1, 0, 4'd2, 32'h22222222};
    vecs[8]  = '{0, 1, 0, 1, 32'h33333333,   1,  0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 4'd2, 32'h33333333};
    vecs[9]  = '{0, 1, 0, 1, 32'h0,          1,  1, 2'b10, 0, 0, 1, 2'b10, 1, 0, 4'd2, 32'h33333333};
    vecs[10] = '{0, 1, 0, 1, 32'h0,          1,  0, 2'b00, 1, 0, 0, 2'b00, 1, 0, 4'd3, 32'h33333333};
    vecs[11] = '{0, 1, 0, 1, 32'h44444444,   1,  0, 2'b00, 0, 1, 0, 2'b00, 1, 0, 4'd3, 32'h44444444};
    vecs[12] = '{0, 1, 0, 1, 32'h0,          1,  1, 2'b11, 0, 0, 0, 2'b00, 0, 1, 4'd3, 32'h44444444};
    vecs[13] = '{0, 1, 0, 1, 32'h0,          1,  0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 4'd3, 32'h44444444};
    vecs[14] = '{1, 1, 0, 1, 32'h0,          1,  0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 4'd0, 32'h0};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].rn, vecs[i].hlt, vecs[i].ack, vecs[i].rdata,
            vecs[i].rdy, vecs[i].rv, vecs[i].sel);
      tick();
      chk($sformatf("vec%0d", i), 64'(outs()),
          64'({vecs[i].e_req, vecs[i].e_valid, vecs[i].e_pcen, vecs[i].e_src,
               vecs[i].e_busy, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_instr}));
    end

    // Fetch timeout: eight no-ack FETCH cycles end in ERROR.
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 2'b00); tick();
    chk("timeout_enter_fetch", 64'(imem_req), 64'(1));
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("timeout_wait%0d", k), 64'({imem_req, fetch_err}), 64'(2'b10));
    end
    tick();
    chk("timeout_error", 64'({imem_req, busy, fetch_err}), 64'(3'b001));

    // Ack on the eighth FETCH cycle still delivers.
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 2'b00); tick();
    repeat (7) tick();
    drive(0, 1, 0, 1, 32'h5A5AC3C3, 0, 0, 2'b00); tick();
    chk("late_ack_deliver", 64'({instr_valid, fetch_err, instr}), 64'({2'b10, 32'h5A5AC3C3}));

    // Decode stall: word and valid held while instr_ready stays low.
    drive(0, 1, 0, 1, 32'hFFFF0000, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d", k), 64'({instr_valid, pc_en, instr}), 64'({2'b10, 32'h5A5AC3C3}));
    end
    drive(0, 1, 0, 1, 32'hFFFF0000, 1, 0, 2'b00); tick();
    chk("stall_release", 64'({pc_en, PC_src}), 64'(3'b100));

    // Halt pulse in FETCH: in-flight instruction commits once, then HALTED.
    drive(0, 1, 0, 0, 0, 0, 0, 2'b00); tick();
    chk("halt_fetch", 64'(imem_req), 64'(1));
    pulses = 0;
    drive(0, 1, 1, 0, 0, 0, 0, 2'b00); tick(); pulses += int'(pc_en);
    drive(0, 1, 0, 1, 32'h600DF00D, 0, 0, 2'b00); tick(); pulses += int'(pc_en);
    drive(0, 1, 0, 0, 0, 1, 0, 2'b00); tick(); pulses += int'(pc_en);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00); tick(); pulses += int'(pc_en);
    chk("halted", 64'({busy, imem_req, instr_valid, pc_en}), 64'(0));
    tick(); pulses += int'(pc_en);
    drive(0, 1, 1, 0, 0, 0, 0, 2'b00); tick(); pulses += int'(pc_en);
    chk("halt_wins", 64'({busy, imem_req}), 64'(0));
    chk("halt_one_pc_en", 64'(pulses), 64'(1));
    drive(0, 1, 0, 0, 0, 0, 0, 2'b00); tick();
    chk("resume_fetch", 64'({imem_req, busy}), 64'(2'b11));

    // Counter wraps after 16 retirements (CNT_W=4).
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00); tick();
    drive(0, 1, 0, 1, 32'h12345678, 1, 0, 2'b00); tick();
    for (int i = 1; i <= 16; i++) begin
      repeat (3) tick();
      chk($sformatf("wrap_cnt%0d", i), 64'(instr_count), 64'(i % 16));
    end

    // Reset while DELIVER abandons the instruction; held reset ignores run.
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00); tick();
    drive(0, 1, 0, 1, 32'hCAFEBABE, 0, 0, 2'b00); tick(); tick();
    chk("rst_in_deliver_pre", 64'(instr_valid), 64'(1));
    drive(1, 1, 0, 1, 32'hCAFEBABE, 1, 0, 2'b00); tick();
    chk("rst_in_deliver", 64'(outs()), 64'(0));
    tick();
    chk("rst_held", 64'(outs()), 64'(0));
    drive(0, 1, 0, 0, 0, 0, 0, 2'b00); tick();
    chk("rst_release", 64'(imem_req), 64'(1));

    // Randomized run against the reference model.
    drive(1, 0, 0, 0, 0, 0, 0, 2'b00);
    model_step(); tick();
    chk("rand_reset", 64'(outs()), 64'(model_outs()));
    drought = 0;
    for (int c = 0; c < 4000; c++) begin
      if (drought == 0 && $urandom_range(0, 149) == 0) drought = int'($urandom_range(6, 9));
      d = $urandom();
      reset          = ($urandom_range(0, 119) == 0);
      run            = ($urandom_range(0, 9) != 0);
      halt_req       = ($urandom_range(0, 24) == 0);
      imem_ack       = (drought > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      imem_rdata     = d;
      instr_ready    = ($urandom_range(0, 2) != 0);
      redirect_valid = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 19) == 0)
        redirect_sel = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else
        redirect_sel = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      if (drought > 0) drought--;
      model_step();
      tick();
      chk("rand", 64'(outs()), 64'(model_outs()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
